hold_swap_ctrl: RTL

- Sequences the Tetris hold/swap operation around the hold-piece register: detects the hold key during play, captures the active piece, and supplies the replacement piece.
- Replacement is either the previously held piece or a fresh piece fetched from the next-piece queue over a req/ack handshake.
- Enforces one swap per dropped piece and one swap per key press.
- Sits between keyboard decode, the game FSM, the next-piece queue and the spawn logic.

---
 rtl/tetris_pkg.sv | 15 +
 rtl/hold_swap_ctrl_if.sv | 25 ++
 rtl/hold_swap_ctrl_key_edge.sv | 55 +++++
 rtl/hold_swap_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece geometry, game-state codes and key codes
// used by the hold/swap controller and the other key handlers.
package tetris_pkg;
  localparam int BLOCK_W = 10;
  localparam int BLOCK_N = 2;

  typedef logic [BLOCK_N-1:0][BLOCK_W-1:0] block_t;

  localparam logic [2:0] ST_SPAWN = 3'b010;
  localparam logic [2:0] ST_PLAY  = 3'b100;

  localparam logic [7:0] KEY_HOLD = 8'h06;

  localparam int DEBOUNCE_CYC = 4;
endpackage

// File: rtl/hold_swap_ctrl_if.sv
// Piece handshakes of the hold/swap controller: next-piece fetch (req/ack)
// and spawn offer (valid/ready).
interface hold_swap_ctrl_if;
  import tetris_pkg::*;

  // next_req stays high until a cycle with next_ack; next_block is taken on
  // that cycle. spawn_block is held stable while spawn_valid is high and moves
  // on the cycle where spawn_valid && spawn_ready.
  logic   next_req;
  logic   next_ack;
  block_t next_block;
  logic   spawn_valid;
  logic   spawn_ready;
  block_t spawn_block;

  modport master (
    output next_req, spawn_valid, spawn_block,
    input  next_ack, next_block, spawn_ready
  );

  modport slave (
    input  next_req, spawn_valid, spawn_block,
    output next_ack, next_block, spawn_ready
  );
endinterface

// File: rtl/hold_swap_ctrl_key_edge.sv
// key_edge_detect: one-cycle trig on the press of a given key. Optional
// debounce selected by HOLD_DEBOUNCE_EN.
module key_edge_detect #(
    parameter logic [7:0] KEY          = 8'h06,
    parameter int         DEBOUNCE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    output logic       trig
);
    logic hit;
    logic prev_hit;

    assign hit = (keycode == KEY);

`ifdef HOLD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          sample_q;
    logic [CW-1:0] cnt;
    logic          stable;

    // cnt is the run length of sample_q; the debounced level only moves once
    // that run reaches DEBOUNCE_CYC.
    assign stable = (cnt >= CW'(DEBOUNCE_CYC));
    assign trig   = stable && sample_q && !prev_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= 1'b0;
            cnt      <= '0;
            prev_hit <= 1'b0;
        end else begin
            sample_q <= hit;
            if (hit != sample_q)
                cnt <= CW'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            if (stable)
                prev_hit <= sample_q;
        end
    end
`else
    assign trig = hit && !prev_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prev_hit <= 1'b0;
        else
            prev_hit <= hit;
    end
`endif
endmodule

// File: rtl/hold_swap_ctrl.sv
// Tetris hold/swap sequencer: captures the active piece into the hold slot and
// offers the previously held (or a freshly fetched) piece to spawn.
// Optional key debounce: define HOLD_DEBOUNCE_EN.
module hold_swap_ctrl
    import tetris_pkg::*;
#(
    parameter logic [7:0] HOLD_KEY       = KEY_HOLD,
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           keycode,
    input  logic [2:0]           game_state,
    input  block_t               cur_block,
    hold_swap_ctrl_if.master     bus,
    output block_t               hold_block,
    output logic                 hold_empty,
    output logic                 can_swap,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FETCH   = 2'd2,
        S_OFFER   = 2'd3
    } state_e;

    state_e state_q, state_d;
    block_t hold_d;
    logic   hold_empty_d;
    logic   can_swap_d;
    block_t spawn_q, spawn_d;
    logic   trig;

    key_edge_detect #(
        .KEY          (HOLD_KEY),
        .DEBOUNCE_CYC (DEBOUNCE_CYCLES)
    ) u_key (
        .clk     (clk),
        .reset   (reset),
        .keycode (keycode),
        .trig    (trig)
    );

    // Handshake outputs decode straight from the state register so the
    // asynchronous reset drops them without waiting for a clock.
    assign bus.next_req    = (state_q == S_FETCH);
    assign bus.spawn_valid = (state_q == S_OFFER);
    assign bus.spawn_block = spawn_q;
    assign busy            = (state_q != S_IDLE);
    assign state_dbg       = state_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_block;
        hold_empty_d = hold_empty;
        can_swap_d   = can_swap;
        spawn_d      = spawn_q;

        if (game_state == ST_SPAWN)
            can_swap_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (trig && (game_state == ST_PLAY) && can_swap) begin
                    can_swap_d = 1'b0;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                hold_d = cur_block;
                if (hold_empty) begin
                    hold_empty_d = 1'b0;
                    state_d      = S_FETCH;
                end else begin
                    spawn_d = hold_block;
                    state_d = S_OFFER;
                end
            end
            S_FETCH: begin
                if (bus.next_ack) begin
                    spawn_d = bus.next_block;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.spawn_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hold_block <= '0;
            hold_empty <= 1'b1;
            can_swap   <= 1'b1;
            spawn_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_block <= hold_d;
            hold_empty <= hold_empty_d;
            can_swap   <= can_swap_d;
            spawn_q    <= spawn_d;
        end
    end
endmodule
